// File: rtl/mps_intl_pkg.sv
// -----------------------------------------------------------------------------
// mps_intl_pkg
// Shared constants and types for the MPS analog interlock detector.
//   - channel count and channel index width
//   - per-channel limit record {hi, lo, dly}
//   - reset-default limits (widest window, so no channel can trip)
//   - helper that maps a zero delay setting onto one sample
// -----------------------------------------------------------------------------
package mps_intl_pkg;

   localparam int MPS_INTL_CH_NUM = 18;
   localparam int MPS_INTL_CH_W   = 5;
   localparam int MPS_INTL_DATA_W = 16;
   localparam int MPS_INTL_CNT_W  = 16;

   // First channel index that is out of range.
   localparam logic [MPS_INTL_CH_W-1:0] MPS_INTL_CH_LIMIT = 5'd18;

   typedef struct packed {
      logic signed [MPS_INTL_DATA_W-1:0] hi;
      logic signed [MPS_INTL_DATA_W-1:0] lo;
      logic        [MPS_INTL_CNT_W-1:0]  dly;
   } mps_intl_limit_t;

   localparam logic signed [MPS_INTL_DATA_W-1:0] MPS_INTL_HI_RST  = 16'sh7FFF;
   localparam logic signed [MPS_INTL_DATA_W-1:0] MPS_INTL_LO_RST  = 16'sh8000;
   localparam logic        [MPS_INTL_CNT_W-1:0]  MPS_INTL_DLY_RST = 16'd1;

   localparam mps_intl_limit_t MPS_INTL_LIMIT_RST = '{
      hi:  MPS_INTL_HI_RST,
      lo:  MPS_INTL_LO_RST,
      dly: MPS_INTL_DLY_RST
   };

   // A delay of zero would trip before any sample is seen; treat it as one.
   function automatic logic [MPS_INTL_CNT_W-1:0] mps_intl_eff_dly(
      input logic [MPS_INTL_CNT_W-1:0] dly
   );
      mps_intl_eff_dly = (dly == 16'd0) ? 16'd1 : dly;
   endfunction

endpackage

// File: rtl/mps_intl_limit_regs.sv
// -----------------------------------------------------------------------------
// mps_intl_limit_regs
// Per-channel limit register file with synchronous write and registered read.
// A read and a write to the same channel on one edge return the old contents;
// the new values are visible from the following cycle.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-low reset
//   wr_en, wr_ch          write strobe and channel (channel >= 18 ignored)
//   wr_hi, wr_lo, wr_dly  values to store
//   rd_ch                 channel to read (registered)
//   rd_hi, rd_lo, rd_dly  registered read data (defaults for channel >= 18)
// -----------------------------------------------------------------------------
module mps_intl_limit_regs
   import mps_intl_pkg::*;
(
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              wr_en,
   input  logic [MPS_INTL_CH_W-1:0]          wr_ch,
   input  logic signed [MPS_INTL_DATA_W-1:0] wr_hi,
   input  logic signed [MPS_INTL_DATA_W-1:0] wr_lo,
   input  logic [MPS_INTL_CNT_W-1:0]         wr_dly,
   input  logic [MPS_INTL_CH_W-1:0]          rd_ch,
   output logic signed [MPS_INTL_DATA_W-1:0] rd_hi,
   output logic signed [MPS_INTL_DATA_W-1:0] rd_lo,
   output logic [MPS_INTL_CNT_W-1:0]         rd_dly
);

   mps_intl_limit_t lim_r [MPS_INTL_CH_NUM];
   mps_intl_limit_t rd_r;

   // Storage write and registered read; nonblocking order gives read-before-write.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 0; i < MPS_INTL_CH_NUM; i++) begin
            lim_r[i] <= MPS_INTL_LIMIT_RST;
         end
         rd_r <= MPS_INTL_LIMIT_RST;
      end else begin
         if (wr_en && (wr_ch < MPS_INTL_CH_LIMIT)) begin
            lim_r[wr_ch] <= '{hi: wr_hi, lo: wr_lo, dly: wr_dly};
         end
         if (rd_ch < MPS_INTL_CH_LIMIT) begin
            rd_r <= lim_r[rd_ch];
         end else begin
            rd_r <= MPS_INTL_LIMIT_RST;
         end
      end
   end

   assign rd_hi  = rd_r.hi;
   assign rd_lo  = rd_r.lo;
   assign rd_dly = rd_r.dly;

endmodule

// File: rtl/mps_analog_intl_detect.sv
// -----------------------------------------------------------------------------
// mps_analog_intl_detect
// Checks a channel-tagged ADC stream against per-channel signed limits,
// debounces consecutive out-of-range samples and latches tripped channels
// until i_intl_clr.  Three-stage pipeline, one sample per cycle, no stall:
// a sample accepted at edge E0 updates the latch at edge E0+3.
// Ports:
//   i_clk, i_rst                   clock, asynchronous active-low reset
//   i_adc_valid/ch/data            sample stream
//   i_cfg_we/ch/hi/lo/dly          limit configuration write
//   i_intl_en                      per-channel enable mask
//   i_intl_clr                     clear of all latches, counters, first fault
//   o_analog_intl, o_intl_any      latched trip vector and its OR
//   o_first_ch, o_first_valid      first channel to trip since last clear
//   o_first_ts                     cycle stamp of first trip (optional)
// Build option: define MPS_INTL_TRIP_TIMESTAMP_EN to add the 32-bit free-running
// cycle counter and the o_first_ts output.
// -----------------------------------------------------------------------------
module mps_analog_intl_detect
   import mps_intl_pkg::*;
(
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_adc_valid,
   input  logic [4:0]                        i_adc_ch,
   input  logic signed [MPS_INTL_DATA_W-1:0] i_adc_data,
   input  logic                              i_cfg_we,
   input  logic [4:0]                        i_cfg_ch,
   input  logic signed [MPS_INTL_DATA_W-1:0] i_cfg_hi,
   input  logic signed [MPS_INTL_DATA_W-1:0] i_cfg_lo,
   input  logic [MPS_INTL_CNT_W-1:0]         i_cfg_dly,
   input  logic [MPS_INTL_CH_NUM-1:0]        i_intl_en,
   input  logic                              i_intl_clr,
   output logic [MPS_INTL_CH_NUM-1:0]        o_analog_intl,
   output logic                              o_intl_any,
   output logic [4:0]                        o_first_ch,
   output logic                              o_first_valid
`ifdef MPS_INTL_TRIP_TIMESTAMP_EN
  ,output logic [31:0]                       o_first_ts
`endif
);

   localparam int CH_NUM = MPS_INTL_CH_NUM;
   localparam int DATA_W = MPS_INTL_DATA_W;
   localparam int CNT_W  = MPS_INTL_CNT_W;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // S0: registered sample and limits read on the same edge
   logic                     s0_valid_s;
   logic                     s0_valid_r;
   logic [4:0]               s0_ch_r;
   logic signed [DATA_W-1:0] s0_data_r;
   logic signed [DATA_W-1:0] lim_hi_s;
   logic signed [DATA_W-1:0] lim_lo_s;
   logic [CNT_W-1:0]         lim_dly_s;

   // S1: compare result
   logic                     s1_oor_s;
   logic                     s1_valid_r;
   logic [4:0]               s1_ch_r;
   logic                     s1_oor_r;
   logic [CNT_W-1:0]         s1_dly_r;

   // S2: counter/latch update inputs
   logic                     s2_valid_r;
   logic [4:0]               s2_ch_r;
   logic                     s2_oor_r;
   logic [CNT_W-1:0]         s2_dly_r;

   logic [CNT_W-1:0]         cnt_r     [CH_NUM];
   logic [CNT_W-1:0]         cnt_nxt_s [CH_NUM];
   logic [CNT_W-1:0]         cnt_inc_s;
   logic                     trip_s;
   logic [CH_NUM-1:0]        trip_vec_s;
   logic [CH_NUM-1:0]        latch_nxt_s;
   logic                     first_valid_nxt_s;
   logic [4:0]               first_ch_nxt_s;

`ifdef MPS_INTL_TRIP_TIMESTAMP_EN
   logic [31:0]              ts_cnt_r;
`endif

   // Out-of-range channel tags never enter the pipeline.
   assign s0_valid_s = i_adc_valid && (i_adc_ch < MPS_INTL_CH_LIMIT);

   mps_intl_limit_regs u_limit_regs (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .wr_en  (i_cfg_we),
      .wr_ch  (i_cfg_ch),
      .wr_hi  (i_cfg_hi),
      .wr_lo  (i_cfg_lo),
      .wr_dly (i_cfg_dly),
      .rd_ch  (i_adc_ch),
      .rd_hi  (lim_hi_s),
      .rd_lo  (lim_lo_s),
      .rd_dly (lim_dly_s)
   );

   // Strict signed window; an inverted window (hi < lo) flags every sample.
   assign s1_oor_s = (s0_data_r > lim_hi_s) || (s0_data_r < lim_lo_s);

   // Next-state of debounce counters, latches and first-fault capture.
   always_comb begin
      cnt_inc_s         = {CNT_W{1'b0}};
      trip_s            = 1'b0;
      trip_vec_s        = {CH_NUM{1'b0}};
      latch_nxt_s       = o_analog_intl;
      first_valid_nxt_s = o_first_valid;
      first_ch_nxt_s    = o_first_ch;
      for (int c = 0; c < CH_NUM; c++) begin
         // A disabled channel keeps its counter pinned at zero.
         cnt_nxt_s[c] = i_intl_en[c] ? cnt_r[c] : {CNT_W{1'b0}};
      end

      if (s2_valid_r && i_intl_en[s2_ch_r]) begin
         if (s2_oor_r) begin
            cnt_inc_s          = (cnt_r[s2_ch_r] == CNT_MAX) ? CNT_MAX
                                                             : (cnt_r[s2_ch_r] + CNT_ONE);
            cnt_nxt_s[s2_ch_r] = cnt_inc_s;
            trip_s             = (cnt_inc_s >= mps_intl_eff_dly(s2_dly_r));
         end else begin
            cnt_nxt_s[s2_ch_r] = {CNT_W{1'b0}};
         end
      end else begin
         trip_s = 1'b0;
      end

      trip_vec_s[s2_ch_r] = trip_s;

      if (i_intl_clr) begin
         // A trip landing on the clear edge survives, counter included.
         for (int c = 0; c < CH_NUM; c++) begin
            if (!(trip_s && (5'(c) == s2_ch_r))) begin
               cnt_nxt_s[c] = {CNT_W{1'b0}};
            end else begin
               cnt_nxt_s[c] = cnt_nxt_s[c];
            end
         end
         latch_nxt_s       = trip_vec_s;
         first_valid_nxt_s = trip_s;
         first_ch_nxt_s    = trip_s ? s2_ch_r : 5'd0;
      end else begin
         latch_nxt_s = o_analog_intl | trip_vec_s;
         if (!o_first_valid && trip_s) begin
            first_valid_nxt_s = 1'b1;
            first_ch_nxt_s    = s2_ch_r;
         end else begin
            first_valid_nxt_s = o_first_valid;
            first_ch_nxt_s    = o_first_ch;
         end
      end
   end

   // Pipeline registers, counters and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         s0_valid_r    <= 1'b0;
         s0_ch_r       <= 5'd0;
         s0_data_r     <= {DATA_W{1'b0}};
         s1_valid_r    <= 1'b0;
         s1_ch_r       <= 5'd0;
         s1_oor_r      <= 1'b0;
         s1_dly_r      <= {CNT_W{1'b0}};
         s2_valid_r    <= 1'b0;
         s2_ch_r       <= 5'd0;
         s2_oor_r      <= 1'b0;
         s2_dly_r      <= {CNT_W{1'b0}};
         for (int c = 0; c < CH_NUM; c++) begin
            cnt_r[c] <= {CNT_W{1'b0}};
         end
         o_analog_intl <= {CH_NUM{1'b0}};
         o_intl_any    <= 1'b0;
         o_first_ch    <= 5'd0;
         o_first_valid <= 1'b0;
`ifdef MPS_INTL_TRIP_TIMESTAMP_EN
         ts_cnt_r      <= 32'd0;
         o_first_ts    <= 32'd0;
`endif
      end else begin
         // Channel index is zeroed for idle slots so S2 never indexes past CH_NUM.
         s0_valid_r    <= s0_valid_s;
         s0_ch_r       <= s0_valid_s ? i_adc_ch : 5'd0;
         s0_data_r     <= i_adc_data;
         s1_valid_r    <= s0_valid_r;
         s1_ch_r       <= s0_ch_r;
         s1_oor_r      <= s1_oor_s;
         s1_dly_r      <= lim_dly_s;
         s2_valid_r    <= s1_valid_r;
         s2_ch_r       <= s1_ch_r;
         s2_oor_r      <= s1_oor_r;
         s2_dly_r      <= s1_dly_r;
         for (int c = 0; c < CH_NUM; c++) begin
            cnt_r[c] <= cnt_nxt_s[c];
         end
         o_analog_intl <= latch_nxt_s;
         o_intl_any    <= |latch_nxt_s;
         o_first_ch    <= first_ch_nxt_s;
         o_first_valid <= first_valid_nxt_s;
`ifdef MPS_INTL_TRIP_TIMESTAMP_EN
         ts_cnt_r      <= ts_cnt_r + 32'd1;
         if (i_intl_clr) begin
            o_first_ts <= trip_s ? ts_cnt_r : 32'd0;
         end else if (!o_first_valid && trip_s) begin
            o_first_ts <= ts_cnt_r;
         end
`endif
      end
   end

endmodule

// File: tb/tb_mps_analog_intl_detect.sv
// -----------------------------------------------------------------------------
// tb_mps_analog_intl_detect
// Directed bench for mps_analog_intl_detect (default build).  Inputs change
// 1 time unit after the rising edge; outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_mps_analog_intl_detect;

   logic               i_clk = 1'b0;
   logic               i_rst;
   logic               i_adc_valid;
   logic [4:0]         i_adc_ch;
   logic signed [15:0] i_adc_data;
   logic               i_cfg_we;
   logic [4:0]         i_cfg_ch;
   logic signed [15:0] i_cfg_hi;
   logic signed [15:0] i_cfg_lo;
   logic [15:0]        i_cfg_dly;
   logic [17:0]        i_intl_en;
   logic               i_intl_clr;
   logic [17:0]        o_analog_intl;
   logic               o_intl_any;
   logic [4:0]         o_first_ch;
   logic               o_first_valid;

   int n_vec = 0;
   int n_err = 0;

   mps_analog_intl_detect dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_adc_valid   (i_adc_valid),
      .i_adc_ch      (i_adc_ch),
      .i_adc_data    (i_adc_data),
      .i_cfg_we      (i_cfg_we),
      .i_cfg_ch      (i_cfg_ch),
      .i_cfg_hi      (i_cfg_hi),
      .i_cfg_lo      (i_cfg_lo),
      .i_cfg_dly     (i_cfg_dly),
      .i_intl_en     (i_intl_en),
      .i_intl_clr    (i_intl_clr),
      .o_analog_intl (o_analog_intl),
      .o_intl_any    (o_intl_any),
      .o_first_ch    (o_first_ch),
      .o_first_valid (o_first_valid)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [4:0] ch, input logic signed [15:0] data);
      i_adc_valid = 1'b1;
      i_adc_ch    = ch;
      i_adc_data  = data;
      tick();
      i_adc_valid = 1'b0;
   endtask

   task automatic cfg(input logic [4:0] ch, input logic signed [15:0] hi,
                      input logic signed [15:0] lo, input logic [15:0] dly);
      i_cfg_we  = 1'b1;
      i_cfg_ch  = ch;
      i_cfg_hi  = hi;
      i_cfg_lo  = lo;
      i_cfg_dly = dly;
      tick();
      i_cfg_we  = 1'b0;
   endtask

   task automatic flush();
      repeat (4) tick();
   endtask

   task automatic clear();
      i_intl_clr = 1'b1;
      tick();
      i_intl_clr = 1'b0;
   endtask

   initial begin
      i_rst       = 1'b0;
      i_adc_valid = 1'b0;
      i_adc_ch    = 5'd0;
      i_adc_data  = 16'sd0;
      i_cfg_we    = 1'b0;
      i_cfg_ch    = 5'd0;
      i_cfg_hi    = 16'sd0;
      i_cfg_lo    = 16'sd0;
      i_cfg_dly   = 16'd0;
      i_intl_en   = 18'h3FFFF;
      i_intl_clr  = 1'b0;

      // Reset state
      repeat (2) tick();
      chk("rst_intl",  32'(o_analog_intl), 32'h0);
      chk("rst_any",   32'(o_intl_any),    32'h0);
      chk("rst_fch",   32'(o_first_ch),    32'h0);
      chk("rst_fval",  32'(o_first_valid), 32'h0);
      i_rst = 1'b1;
      tick();

      // Pass / no-trip: never 4 consecutive out-of-range samples
      cfg(5'd3, 16'sd1000, -16'sd1000, 16'd4);
      repeat (3) send(5'd3, 16'sd1200);
      send(5'd3, 16'sd0);
      repeat (3) send(5'd3, 16'sd1200);
      send(5'd3, 16'sd0);
      flush();
      chk("notrip_intl", 32'(o_analog_intl), 32'h0);

      // Trip on the 4th sample, exactly 3 edges after it
      repeat (4) send(5'd3, 16'sd1001);
      tick(); tick();
      chk("trip_early", 32'(o_analog_intl), 32'h0);
      tick();
      chk("trip_intl", 32'(o_analog_intl), 32'h8);
      chk("trip_any",  32'(o_intl_any),    32'h1);
      chk("trip_fch",  32'(o_first_ch),    32'h3);
      chk("trip_fval", 32'(o_first_valid), 32'h1);
      repeat (3) send(5'd3, 16'sd0);
      flush();
      chk("latch_hold", 32'(o_analog_intl), 32'h8);
      clear();
      chk("clr_intl", 32'(o_analog_intl), 32'h0);
      chk("clr_any",  32'(o_intl_any),    32'h0);
      chk("clr_fch",  32'(o_first_ch),    32'h0);
      chk("clr_fval", 32'(o_first_valid), 32'h0);

      // Signed low limit (strict) and first-fault priority
      cfg(5'd0, 16'sd32767, -16'sd50, 16'd1);
      cfg(5'd17, 16'sd100, -16'sd100, 16'd1);
      send(5'd0, -16'sd50);
      flush();
      chk("lo_equal", 32'(o_analog_intl), 32'h0);
      send(5'd0, -16'sd51);
      send(5'd17, 16'sd200);
      flush();
      chk("lo_intl", 32'(o_analog_intl), 32'h20001);
      chk("lo_fch",  32'(o_first_ch),    32'h0);
      chk("lo_fval", 32'(o_first_valid), 32'h1);
      chk("lo_any",  32'(o_intl_any),    32'h1);
      clear();

      // Disabled channel and out-of-range channel tags
      i_intl_en = 18'h3FFDF;
      cfg(5'd5, 16'sd100, -16'sd100, 16'd1);
      repeat (10) send(5'd5, 16'sd32767);
      send(5'd20, 16'sd32767);
      send(5'd31, -16'sd32768);
      flush();
      chk("dis_intl", 32'(o_analog_intl), 32'h0);
      chk("dis_fval", 32'(o_first_valid), 32'h0);
      i_intl_en = 18'h3FFFF;

      // Clear arriving on the same edge as a ch7 trip
      send(5'd0, -16'sd100);
      flush();
      chk("pre_col_intl", 32'(o_analog_intl), 32'h1);
      cfg(5'd7, 16'sd100, -16'sd100, 16'd1);
      send(5'd7, 16'sd500);
      tick(); tick();
      i_intl_clr = 1'b1;
      tick();
      i_intl_clr = 1'b0;
      chk("col_intl", 32'(o_analog_intl), 32'h80);
      chk("col_fch",  32'(o_first_ch),    32'h7);
      chk("col_fval", 32'(o_first_valid), 32'h1);
      tick();
      chk("col_hold", 32'(o_analog_intl), 32'h80);
      clear();

      // Config write racing a sample on the same channel
      i_cfg_we    = 1'b1;
      i_cfg_ch    = 5'd2;
      i_cfg_hi    = 16'sd0;
      i_cfg_lo    = -16'sd100;
      i_cfg_dly   = 16'd1;
      i_adc_valid = 1'b1;
      i_adc_ch    = 5'd2;
      i_adc_data  = 16'sd10;
      tick();
      i_cfg_we    = 1'b0;
      tick();
      i_adc_valid = 1'b0;
      tick(); tick();
      chk("race_old", 32'(o_analog_intl), 32'h0);
      tick();
      chk("race_new", 32'(o_analog_intl), 32'h4);
      chk("race_fch", 32'(o_first_ch),    32'h2);

      // Asynchronous reset with samples in flight
      i_adc_valid = 1'b1;
      i_adc_ch    = 5'd2;
      i_adc_data  = 16'sd10;
      tick(); tick();
      i_rst = 1'b0;
      #1;
      chk("arst_intl", 32'(o_analog_intl), 32'h0);
      chk("arst_any",  32'(o_intl_any),    32'h0);
      chk("arst_fval", 32'(o_first_valid), 32'h0);
      tick();
      i_adc_valid = 1'b0;
      i_rst = 1'b1;
      flush();
      chk("post_rst_intl", 32'(o_analog_intl), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
